pipe_stage_skid: RTL

//  Generic ready/valid pipeline stage register; replaces fixed per-stage regs (ID->EXE, EXE->MEM, ...).
//  2-entry skid buffer: full throughput with registered in_ready, synchronous flush, NOP bubble on flush.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stat_cnt.sv | 24 ++
 rtl/pipe_stage_skid.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: bundle field widths and
// the occupancy-encoded state of the skid stage.
package pipe_pkg;

  localparam int unsigned CTRL_W    = 5;
  localparam int unsigned EXE_CMD_W = 4;
  localparam int unsigned DEST_W    = 4;
  localparam int unsigned SHIFT_W   = 12;
  localparam int unsigned IMM24_W   = 24;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned IMM_W     = 1;

  // ID->EXE bundle: ctrl, exe_cmd, PC/Rn/Rm, imm flag, shift operand, imm24, dest.
  localparam int unsigned ID_EXE_W = CTRL_W + EXE_CMD_W + 3 * WORD_W + IMM_W + SHIFT_W +
                                     IMM24_W + DEST_W;

  // Encoding equals the number of entries held, so occ is the state register itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stat_cnt.sv
// Saturating event counter; cleared only by reset.
module pipe_stat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q;

  // Count events, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {Width{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Ready/valid pipeline stage with a 2-entry skid buffer. in_ready is decoded
// from the state register only, and out_data comes straight from the main
// register, so there is no combinational path from in_* to out_*.
// Optional stall statistics: define PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = ID_EXE_W,
  parameter bit          FLUSH_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush wins over any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (in_fire) state_d = StOne;
        StOne: begin
          if (in_fire && !out_fire) begin
            state_d = StFull;
          end else if (!in_fire && out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (out_fire) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occ       = 2'd0;
    unique case (state_q)
      StEmpty: ;
      StOne: begin
        out_valid = 1'b1;
        occ       = 2'd1;
      end
      StFull: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occ       = 2'd2;
      end
      default: ;
    endcase
  end

  // Payload steering: main always holds the older entry, skid the newer one.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      if (FLUSH_ZERO) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: if (in_fire) main_d = in_data;
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d = in_data;
          end
        end
        StFull:  if (out_fire) main_d = skid_q;
        default: ;
      endcase
    end
  end

  // Payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_data = main_q;

`ifdef PIPE_STAGE_STATS_EN
  pipe_stat_cnt #(
    .Width(CNT_W)
  ) u_stat_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid & ~out_ready),
    .cnt  (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule
